// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: scanout reads own every slot they request, draw writes are
// queued in a small FIFO and drain one per cycle in which no scanout read is requested.
module vga_fb_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int RD_LAT     = 2
) (
    input  logic                            iCLK,
    input  logic                            iRST_N,
    input  logic                            iDISP_REQ,
    input  logic [ADDR_W-1:0]               iDISP_ADDR,
    output logic [DATA_W-1:0]               oDISP_DATA,
    output logic                            oDISP_VALID,
    input  logic                            iWR_VALID,
    input  logic [ADDR_W-1:0]               iWR_ADDR,
    input  logic [DATA_W-1:0]               iWR_DATA,
    output logic                            oWR_READY,
    output logic                            oMEM_EN,
    output logic                            oMEM_WE,
    output logic [ADDR_W-1:0]               oMEM_ADDR,
    output logic [DATA_W-1:0]               oMEM_WDATA,
    input  logic [DATA_W-1:0]               iMEM_RDATA,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] oFIFO_LEVEL,
    output logic                            oFIFO_FULL_SEEN
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } slot_e;

    slot_e             state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic              full_seen_q;
    logic [RD_LAT-1:0] rd_pipe_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic              wr_ready;
    logic              push;
    logic              pop;

    // NOTE: every signal gets a default before the if-chain, otherwise a latch is inferred.
    always_comb begin
        wr_ready    = iRST_N && (level_q < FULL_LVL);
        push        = iWR_VALID && wr_ready;
        pop         = 1'b0;
        state_d     = S_IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (iDISP_REQ) begin
            state_d    = S_READ;
            mem_addr_d = iDISP_ADDR;
        end else if (level_q != '0) begin
            state_d     = S_WRITE;
            pop         = 1'b1;
            mem_addr_d  = fifo_addr_q[rd_ptr_q];
            mem_wdata_d = fifo_data_q[rd_ptr_q];
        end
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            level_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            full_seen_q  <= 1'b0;
            rd_pipe_q    <= '0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            level_q     <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (level_d == FULL_LVL) begin
                full_seen_q <= 1'b1;
            end
            // Read slots travel RD_LAT stages, then the RAM data is captured one edge later.
            rd_pipe_q    <= RD_LAT'({rd_pipe_q, state_q == S_READ});
            disp_valid_q <= rd_pipe_q[RD_LAT-1];
            if (rd_pipe_q[RD_LAT-1]) begin
                disp_data_q <= iMEM_RDATA;
            end
        end
    end

    // NOTE: FIFO storage is not reset; level and pointers alone decide which entries are live.
    always_ff @(posedge iCLK) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= iWR_ADDR;
            fifo_data_q[wr_ptr_q] <= iWR_DATA;
        end
    end

    assign oWR_READY       = wr_ready;
    assign oMEM_EN         = (state_q != S_IDLE);
    assign oMEM_WE         = (state_q == S_WRITE);
    assign oMEM_ADDR       = mem_addr_q;
    assign oMEM_WDATA      = mem_wdata_q;
    assign oFIFO_LEVEL     = level_q;
    assign oFIFO_FULL_SEEN = full_seen_q;
    assign oDISP_VALID     = disp_valid_q;
    assign oDISP_DATA      = disp_data_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based reference model and a behavioural RAM.
module tb_vga_fb_arbiter;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int RD_LAT = 2;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } rd_t;

    logic              iCLK = 1'b0;
    logic              iRST_N = 1'b0;
    logic              iDISP_REQ = 1'b0;
    logic [ADDR_W-1:0] iDISP_ADDR = '0;
    logic              iWR_VALID = 1'b0;
    logic [ADDR_W-1:0] iWR_ADDR = '0;
    logic [DATA_W-1:0] iWR_DATA = '0;
    wire  [DATA_W-1:0] iMEM_RDATA;
    logic [DATA_W-1:0] oDISP_DATA;
    logic              oDISP_VALID;
    logic              oWR_READY;
    logic              oMEM_EN;
    logic              oMEM_WE;
    logic [ADDR_W-1:0] oMEM_ADDR;
    logic [DATA_W-1:0] oMEM_WDATA;
    logic [LVL_W-1:0]  oFIFO_LEVEL;
    logic              oFIFO_FULL_SEEN;

    vga_fb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .iCLK(iCLK), .iRST_N(iRST_N),
        .iDISP_REQ(iDISP_REQ), .iDISP_ADDR(iDISP_ADDR),
        .oDISP_DATA(oDISP_DATA), .oDISP_VALID(oDISP_VALID),
        .iWR_VALID(iWR_VALID), .iWR_ADDR(iWR_ADDR), .iWR_DATA(iWR_DATA), .oWR_READY(oWR_READY),
        .oMEM_EN(oMEM_EN), .oMEM_WE(oMEM_WE), .oMEM_ADDR(oMEM_ADDR), .oMEM_WDATA(oMEM_WDATA),
        .iMEM_RDATA(iMEM_RDATA),
        .oFIFO_LEVEL(oFIFO_LEVEL), .oFIFO_FULL_SEEN(oFIFO_FULL_SEEN)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural RAM: samples commands at the edge, read data appears RD_LAT edges later.
    logic [DATA_W-1:0] ram [int];
    logic [DATA_W-1:0] rpipe [RD_LAT];
    assign iMEM_RDATA = rpipe[RD_LAT-1];

    always @(posedge iCLK) begin
        for (int i = RD_LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
        if (oMEM_EN && !oMEM_WE)
            rpipe[0] <= ram.exists(int'(oMEM_ADDR)) ? ram[int'(oMEM_ADDR)] : DATA_W'(oMEM_ADDR);
        if (oMEM_EN && oMEM_WE) ram[int'(oMEM_ADDR)] = oMEM_WDATA;
    end

    // Reference model: FIFO as a queue, framebuffer contents as an associative array,
    // pending scanout returns as a queue of (due cycle, pixel).
    wr_t               mq [$];
    rd_t               rq [$];
    logic [DATA_W-1:0] exp_mem [int];
    logic              m_en = 1'b0, m_we = 1'b0, m_dvalid = 1'b0, m_full = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_ddata = '0;
    bit                started = 1'b0;
    int                cyc = 0;

    function automatic logic [DATA_W-1:0] fb_value(input logic [ADDR_W-1:0] a);
        return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : DATA_W'(a);
    endfunction

    always @(posedge iCLK) begin
        wr_t w;
        bit  take;
        if (!iRST_N) begin
            mq.delete();
            rq.delete();
            {m_en, m_we, m_dvalid, m_full} = '0;
            m_addr  = '0;
            m_wdata = '0;
            m_ddata = '0;
            started = 1'b1;
        end else begin
            take     = iWR_VALID && (mq.size() < DEPTH);
            m_dvalid = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                m_dvalid = 1'b1;
                m_ddata  = rq[0].data;
                void'(rq.pop_front());
            end
            if (iDISP_REQ) begin
                m_en   = 1'b1;
                m_we   = 1'b0;
                m_addr = iDISP_ADDR;
                rq.push_back('{cyc + RD_LAT + 1, fb_value(iDISP_ADDR)});
            end else if (mq.size() > 0) begin
                w       = mq.pop_front();
                m_en    = 1'b1;
                m_we    = 1'b1;
                m_addr  = w.addr;
                m_wdata = w.data;
                exp_mem[int'(w.addr)] = w.data;
            end else begin
                m_en = 1'b0;
                m_we = 1'b0;
            end
            if (take) mq.push_back('{iWR_ADDR, iWR_DATA});
            if (mq.size() == DEPTH) m_full = 1'b1;
        end
        cyc++;
    end

    always @(negedge iCLK) begin
        if (started) begin
            check("mem_en", 32'(oMEM_EN), 32'(m_en));
            check("mem_we", 32'(oMEM_WE), 32'(m_we));
            check("mem_addr", 32'(oMEM_ADDR), 32'(m_addr));
            check("mem_wdata", 32'(oMEM_WDATA), 32'(m_wdata));
            check("disp_valid", 32'(oDISP_VALID), 32'(m_dvalid));
            check("disp_data", 32'(oDISP_DATA), 32'(m_ddata));
            check("wr_ready", 32'(oWR_READY), 32'(iRST_N && (mq.size() < DEPTH)));
            check("fifo_level", 32'(oFIFO_LEVEL), 32'(mq.size()));
            check("full_seen", 32'(oFIFO_FULL_SEEN), 32'(m_full));
        end
    end

    // Write source: the head entry is offered until the DUT takes it.
    wr_t src [$];
    bit  last_acc = 1'b0;

    task automatic step(input logic rst, input logic dreq, input logic [ADDR_W-1:0] daddr);
        @(negedge iCLK);
        #1;
        if (last_acc) void'(src.pop_front());
        iRST_N     = rst;
        iDISP_REQ  = dreq;
        iDISP_ADDR = daddr;
        if (src.size() > 0) begin
            iWR_VALID = 1'b1;
            iWR_ADDR  = src[0].addr;
            iWR_DATA  = src[0].data;
        end else begin
            iWR_VALID = 1'b0;
        end
        #1;
        last_acc = iWR_VALID && oWR_READY;
    endtask

    task automatic add_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        src.push_back('{a, d});
    endtask

    initial begin
        int phase;
        logic [ADDR_W-1:0] new_addr;

        // Reset with inputs toggling randomly.
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            #1;
            iRST_N     = 1'b0;
            iDISP_REQ  = 1'($urandom);
            iDISP_ADDR = ADDR_W'($urandom);
            iWR_VALID  = 1'($urandom);
            iWR_ADDR   = ADDR_W'($urandom);
            iWR_DATA   = DATA_W'($urandom);
        end
        step(1'b1, 1'b0, '0);
        check("ready_after_release", 32'(oWR_READY), 32'd1);
        check("level_after_release", 32'(oFIFO_LEVEL), 32'd0);

        // Back-to-back scanout reads, data equals address.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, ADDR_W'(i));
        repeat (6) step(1'b1, 1'b0, '0);

        // Writes blocked by continuous scanout, then drained in blanking.
        for (int i = 0; i < 10; i++) add_write(ADDR_W'(32'h200 + i), DATA_W'($urandom));
        repeat (12) step(1'b1, 1'b1, ADDR_W'($urandom_range(0, 31)));
        check("fill_level", 32'(oFIFO_LEVEL), 32'd8);
        check("fill_ready", 32'(oWR_READY), 32'd0);
        check("fill_full_seen", 32'(oFIFO_FULL_SEEN), 32'd1);
        repeat (20) step(1'b1, 1'b0, '0);
        check("drain_level", 32'(oFIFO_LEVEL), 32'd0);

        // Write then read of the same pixel.
        add_write(ADDR_W'(32'h00100), 24'hABCDEF);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, ADDR_W'(32'h00100));
        repeat (4) step(1'b1, 1'b0, '0);
        check("raw_valid", 32'(oDISP_VALID), 32'd1);
        check("raw_data", 32'(oDISP_DATA), 32'hABCDEF);

        // Level 7 with simultaneous push and pop.
        for (int i = 0; i < 7; i++) add_write(ADDR_W'(32'h300 + i), DATA_W'($urandom));
        repeat (9) step(1'b1, 1'b1, ADDR_W'($urandom_range(0, 31)));
        for (int i = 0; i < 3; i++) add_write(ADDR_W'(32'h380 + i), DATA_W'($urandom));
        repeat (4) step(1'b1, 1'b0, '0);
        check("pushpop_level7", 32'(oFIFO_LEVEL), 32'd7);
        repeat (12) step(1'b1, 1'b0, '0);

        // Level 1 with simultaneous push and pop: the new entry is the next one out.
        add_write(ADDR_W'(32'h400), 24'h111111);
        repeat (3) step(1'b1, 1'b1, '0);
        new_addr = ADDR_W'(32'h401);
        add_write(new_addr, 24'h222222);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        check("pushpop_level1", 32'(oFIFO_LEVEL), 32'd1);
        step(1'b1, 1'b0, '0);
        check("level1_next_we", 32'(oMEM_WE), 32'd1);
        check("level1_next_addr", 32'(oMEM_ADDR), 32'(new_addr));
        check("level1_next_data", 32'(oMEM_WDATA), 32'h222222);

        // Reset with queued writes and reads in flight.
        for (int i = 0; i < 5; i++) add_write(ADDR_W'(32'h500 + i), DATA_W'($urandom));
        repeat (7) step(1'b1, 1'b1, ADDR_W'($urandom_range(0, 31)));
        step(1'b0, 1'b1, '0);
        repeat (8) step(1'b1, 1'b0, '0);
        check("rst_mid_level", 32'(oFIFO_LEVEL), 32'd0);
        check("rst_mid_en", 32'(oMEM_EN), 32'd0);
        check("rst_mid_valid", 32'(oDISP_VALID), 32'd0);

        // Randomized traffic: scanlines with blanking gaps, occasional resets.
        phase = 0;
        for (int i = 0; i < 3000; i++) begin
            logic dreq;
            if (src.size() < 4 && $urandom_range(0, 1) == 1)
                add_write(ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
            dreq  = (phase < 24) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 7) == 0);
            phase = (phase + 1) % 32;
            step(($urandom_range(0, 299) != 0), dreq, ADDR_W'($urandom_range(0, 31)));
        end
        repeat (8) step(1'b1, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
